axi4_rd_arbiter: RTL and testbench



---
 rtl/axi4_pkg.sv | 43 ++++
 rtl/rr_arb2.sv | 37 +++
 rtl/axi4_rd_arbiter.sv | 118 +++++++++++
 tb/tb_axi4_rd_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_pkg.sv
// AXI4 shared definitions: read-channel bundles plus the read-arbiter FSM type.
//   ar_m : AR request (master -> slave)    ar_s : ARREADY (slave -> master)
//   r_m  : RREADY (master -> slave)        r_s  : R beat  (slave -> master)
package axi4_pkg;

    localparam int unsigned ID_W   = 4;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef struct packed {
        logic              ARVALID;
        logic [ID_W-1:0]   ARID;
        logic [ADDR_W-1:0] ARADDR;
        logic [7:0]        ARLEN;
        logic [2:0]        ARSIZE;
        logic [1:0]        ARBURST;
    } ar_m;

    typedef struct packed {
        logic ARREADY;
    } ar_s;

    typedef struct packed {
        logic RREADY;
    } r_m;

    typedef struct packed {
        logic              RVALID;
        logic [ID_W-1:0]   RID;
        logic [DATA_W-1:0] RDATA;
        logic [1:0]        RRESP;
        logic              RLAST;
    } r_s;

    localparam int unsigned RD_ARB_NREQ = 2;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } rd_arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way winner select for the AXI4 read arbiter.
// Build option: AXI4_RD_ARB_RR_EN selects round-robin (requester not equal to the
// last grant wins a tie); otherwise requester 0 has fixed priority.
//   req_i        : per-requester ARVALID
//   last_grant_i : currently registered grant
//   winner_o     : index of the winning requester (holds last grant when no request)
module rr_arb2
    import axi4_pkg::*;
(
    input  logic [RD_ARB_NREQ-1:0] req_i,
    input  logic                   last_grant_i,
    output logic                   winner_o
);

`ifdef AXI4_RD_ARB_RR_EN
    always_comb begin
        winner_o = last_grant_i;
        if (req_i == 2'b11) begin
            winner_o = ~last_grant_i;
        end else if (req_i[1]) begin
            winner_o = 1'b1;
        end else if (req_i[0]) begin
            winner_o = 1'b0;
        end
    end
`else
    always_comb begin
        winner_o = last_grant_i;
        if (req_i[0]) begin
            winner_o = 1'b0;
        end else if (req_i[1]) begin
            winner_o = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/axi4_rd_arbiter.sv
// Two-requester AXI4 read arbiter: requester 0 (fetch) and requester 1 (load) share
// one AR+R port. One burst at a time; the grant is locked from AR acceptance to RLAST.
// Build option: AXI4_RD_ARB_RR_EN (round-robin tie-break, else fixed priority to 0).
//   ACLK, ARESET         : clock, synchronous active-high reset
//   m0_* / m1_*          : requester AR request/ready and R beat/ready
//   s_ar, s_ar_rdy       : AR to slave / slave ARREADY
//   s_r_rdy, s_r         : RREADY to slave / R beat from slave
//   grant, busy, beat_cnt: status (current/last grant, ADDR|DATA, beats this burst)
module axi4_rd_arbiter
    import axi4_pkg::*;
#(
    parameter int unsigned BEAT_W = 8
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  ar_m               m0_ar,
    output ar_s               m0_ar_rdy,
    input  r_m                m0_r_rdy,
    output r_s                m0_r,
    input  ar_m               m1_ar,
    output ar_s               m1_ar_rdy,
    input  r_m                m1_r_rdy,
    output r_s                m1_r,
    output ar_m               s_ar,
    input  ar_s               s_ar_rdy,
    output r_m                s_r_rdy,
    input  r_s                s_r,
    output logic              grant,
    output logic              busy,
    output logic [BEAT_W-1:0] beat_cnt
);

    rd_arb_state_e     state_q, state_d;
    logic              grant_q, grant_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic              winner;
    ar_m               gnt_ar;
    logic              gnt_rready;
    logic              ar_hs;
    logic              r_hs;

    rr_arb2 u_rr_arb2 (
        .req_i        ({m1_ar.ARVALID, m0_ar.ARVALID}),
        .last_grant_i (grant_q),
        .winner_o     (winner)
    );

    // Routing follows the registered grant only; RID is never inspected.
    always_comb begin
        gnt_ar     = grant_q ? m1_ar : m0_ar;
        gnt_rready = grant_q ? m1_r_rdy.RREADY : m0_r_rdy.RREADY;

        s_ar         = gnt_ar;
        s_ar.ARID    = ID_W'(grant_q);
        s_ar.ARVALID = (state_q == ADDR) && gnt_ar.ARVALID;
        ar_hs        = s_ar.ARVALID && s_ar_rdy.ARREADY;

        m0_ar_rdy.ARREADY = (state_q == ADDR) && !grant_q && s_ar_rdy.ARREADY;
        m1_ar_rdy.ARREADY = (state_q == ADDR) &&  grant_q && s_ar_rdy.ARREADY;

        s_r_rdy.RREADY = (state_q == DATA) && gnt_rready;
        r_hs           = s_r.RVALID && s_r_rdy.RREADY;

        m0_r        = s_r;
        m0_r.RVALID = (state_q == DATA) && !grant_q && s_r.RVALID;
        m1_r        = s_r;
        m1_r.RVALID = (state_q == DATA) &&  grant_q && s_r.RVALID;
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (m0_ar.ARVALID || m1_ar.ARVALID) begin
                    grant_d    = winner;
                    beat_cnt_d = '0;
                    state_d    = ADDR;
                end
            end
            ADDR: begin
                if (ar_hs) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (r_hs) begin
                    if (beat_cnt_q != '1) begin
                        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    end
                    if (s_r.RLAST) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset grant to 1 so requester 0 wins the first round-robin tie.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q    <= IDLE;
            grant_q    <= 1'b1;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign grant    = grant_q;
    assign busy     = (state_q != IDLE);
    assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_axi4_rd_arbiter.sv
// Self-checking bench for axi4_rd_arbiter: bench-side slave and requester models,
// expected AR requests and R beats kept in scoreboard queues.
module tb_axi4_rd_arbiter;
    import axi4_pkg::*;

    localparam int unsigned BEAT_W = 8;

    logic              ACLK = 1'b0;
    logic              ARESET;
    ar_m               m0_ar, m1_ar, s_ar;
    ar_s               m0_ar_rdy, m1_ar_rdy, s_ar_rdy;
    r_m                m0_r_rdy, m1_r_rdy, s_r_rdy;
    r_s                m0_r, m1_r, s_r;
    logic              grant, busy;
    logic [BEAT_W-1:0] beat_cnt;

    always #5 ACLK = ~ACLK;

    axi4_rd_arbiter #(.BEAT_W(BEAT_W)) u_dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .m0_ar     (m0_ar),
        .m0_ar_rdy (m0_ar_rdy),
        .m0_r_rdy  (m0_r_rdy),
        .m0_r      (m0_r),
        .m1_ar     (m1_ar),
        .m1_ar_rdy (m1_ar_rdy),
        .m1_r_rdy  (m1_r_rdy),
        .m1_r      (m1_r),
        .s_ar      (s_ar),
        .s_ar_rdy  (s_ar_rdy),
        .s_r_rdy   (s_r_rdy),
        .s_r       (s_r),
        .grant     (grant),
        .busy      (busy),
        .beat_cnt  (beat_cnt)
    );

    typedef struct { logic req; logic [31:0] addr; logic [7:0] len; } ar_exp_t;
    typedef struct { logic req; logic [31:0] data; logic last; } r_exp_t;

    ar_exp_t exp_ar_q[$];
    r_exp_t  exp_r_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    // Slave model state
    int          ar_wait = 0;
    int          ar_wait_cnt = 0;
    int          r_left = 0;
    int          r_idx = 0;
    logic [31:0] r_base;
    logic [3:0]  r_id;
    logic [31:0] ar_addr_s;
    logic [7:0]  ar_len_s;
    logic [3:0]  ar_id_s;

    // Sampled handshakes and event bookkeeping
    logic ar_hs_s, m0_ar_hs, m1_ar_hs, s_r_hs, m0_r_hs, m1_r_hs;
    logic sar_prev = 1'b0;
    logic busy_prev = 1'b0;
    int   bursts_done = 0, ar_hs_total = 0, m0_beats = 0, m1_beats = 0, m0_rvalid_cnt = 0;
    int   rlast_cyc = 0, sar_rise_cyc = 0, busy_rise_cyc = 0, ar_hs_cyc = 0;
    int   m0_reissue = 0;
    logic [31:0] m0_next_addr;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] data_of(input logic [31:0] a, input int i);
        return {a[15:0], 8'hD0, 8'(i)};
    endfunction

    task automatic sample();
        ar_exp_t ea;
        r_exp_t  er;
        @(negedge ACLK);
        ar_hs_s   = s_ar.ARVALID && s_ar_rdy.ARREADY;
        m0_ar_hs  = m0_ar.ARVALID && m0_ar_rdy.ARREADY;
        m1_ar_hs  = m1_ar.ARVALID && m1_ar_rdy.ARREADY;
        s_r_hs    = s_r.RVALID && s_r_rdy.RREADY;
        m0_r_hs   = m0_r.RVALID && m0_r_rdy.RREADY;
        m1_r_hs   = m1_r.RVALID && m1_r_rdy.RREADY;
        ar_addr_s = s_ar.ARADDR;
        ar_len_s  = s_ar.ARLEN;
        ar_id_s   = s_ar.ARID;
        if (!ARESET) begin
            if (s_ar.ARVALID && !sar_prev) sar_rise_cyc = cyc;
            if (busy && !busy_prev) busy_rise_cyc = cyc;
            if (m0_r.RVALID) m0_rvalid_cnt++;
            if (ar_hs_s) begin
                ar_hs_total++;
                ar_hs_cyc = cyc;
                if (exp_ar_q.size() == 0) begin
                    check_val("ar_unexpected", 1, 0);
                end else begin
                    ea = exp_ar_q.pop_front();
                    check_val("ar_id", s_ar.ARID, 32'(ea.req));
                    check_val("ar_addr", s_ar.ARADDR, ea.addr);
                    check_val("ar_len", s_ar.ARLEN, 32'(ea.len));
                    check_val("ar_rdy_route", {m1_ar_hs, m0_ar_hs}, ea.req ? 2 : 1);
                    for (int i = 0; i <= int'(ea.len); i++) begin
                        er.req  = ea.req;
                        er.data = data_of(ea.addr, i);
                        er.last = (i == int'(ea.len));
                        exp_r_q.push_back(er);
                    end
                end
            end
            if (s_r.RVALID) begin
                check_val("r_excl", m0_r.RVALID & m1_r.RVALID, 0);
                check_val("r_hs_match", s_r_hs, m0_r_hs | m1_r_hs);
            end
            if (m0_r_hs || m1_r_hs) begin
                if (exp_r_q.size() == 0) begin
                    check_val("r_unexpected", 1, 0);
                end else begin
                    er = exp_r_q.pop_front();
                    check_val("r_owner", m1_r_hs, 32'(er.req));
                    check_val("r_data", m1_r_hs ? m1_r.RDATA : m0_r.RDATA, er.data);
                    check_val("r_last", m1_r_hs ? m1_r.RLAST : m0_r.RLAST, 32'(er.last));
                end
            end
            if (m0_r_hs) m0_beats++;
            if (m1_r_hs) m1_beats++;
            if (s_r_hs && s_r.RLAST) begin
                bursts_done++;
                rlast_cyc = cyc;
            end
        end
        sar_prev  = s_ar.ARVALID;
        busy_prev = busy;
    endtask

    task automatic advance();
        @(posedge ACLK);
        #1;
        cyc++;
        if (ARESET) begin
            r_left            = 0;
            ar_wait_cnt       = 0;
            s_r               = '0;
            m0_ar.ARVALID     = 1'b0;
            m1_ar.ARVALID     = 1'b0;
            m0_reissue        = 0;
            s_ar_rdy.ARREADY  = (ar_wait == 0);
            exp_ar_q.delete();
            exp_r_q.delete();
        end else begin
            if (m0_ar_hs) begin
                if (m0_reissue > 0) begin
                    m0_reissue--;
                    m0_ar.ARADDR = m0_next_addr;
                end else begin
                    m0_ar.ARVALID = 1'b0;
                end
            end
            if (m1_ar_hs) m1_ar.ARVALID = 1'b0;
            if (s_r_hs) begin
                r_left--;
                r_idx++;
            end
            if (ar_hs_s) begin
                r_left      = int'(ar_len_s) + 1;
                r_idx       = 0;
                r_base      = ar_addr_s;
                r_id        = ar_id_s;
                ar_wait_cnt = 0;
            end else if (sar_prev) begin
                ar_wait_cnt++;
            end
            s_ar_rdy.ARREADY = (ar_wait_cnt >= ar_wait);
            if (r_left > 0) begin
                s_r.RVALID = 1'b1;
                s_r.RID    = r_id;
                s_r.RDATA  = data_of(r_base, r_idx);
                s_r.RRESP  = 2'b00;
                s_r.RLAST  = (r_left == 1);
            end else begin
                s_r = '0;
            end
        end
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    task automatic set_ar_wait(input int n);
        ar_wait          = n;
        s_ar_rdy.ARREADY = (ar_wait_cnt >= n);
    endtask

    task automatic issue(input logic who, input logic [31:0] addr, input logic [7:0] len);
        ar_m a;
        a         = '0;
        a.ARVALID = 1'b1;
        a.ARID    = 4'hA;
        a.ARADDR  = addr;
        a.ARLEN   = len;
        a.ARSIZE  = 3'd2;
        a.ARBURST = 2'b01;
        if (who) m1_ar = a;
        else     m0_ar = a;
    endtask

    task automatic push_exp(input logic who, input logic [31:0] addr, input logic [7:0] len);
        ar_exp_t e;
        e.req  = who;
        e.addr = addr;
        e.len  = len;
        exp_ar_q.push_back(e);
    endtask

    task automatic wait_bursts(input string tag, input int n);
        int t = 0;
        while (bursts_done < n && t < 300) begin
            tick();
            t++;
        end
        check_val({tag, "_done"}, bursts_done, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int n0, base, b, rl, t, hold;
        ARESET   = 1'b1;
        m0_ar    = '0;
        m1_ar    = '0;
        m0_r_rdy = '{RREADY: 1'b1};
        m1_r_rdy = '{RREADY: 1'b1};
        s_ar_rdy = '0;
        s_r      = '0;
        repeat (3) tick();
        ARESET = 1'b0;

        // Reset state
        sample();
        check_val("rst_busy", busy, 0);
        check_val("rst_grant", grant, 1);
        check_val("rst_beat_cnt", beat_cnt, 0);
        check_val("rst_s_arvalid", s_ar.ARVALID, 0);
        check_val("rst_s_rready", s_r_rdy.RREADY, 0);
        check_val("rst_arready", {m1_ar_rdy.ARREADY, m0_ar_rdy.ARREADY}, 0);
        advance();

        // Lone m1, ARREADY on 2nd ADDR cycle, 4 beats
        set_ar_wait(1);
        n0 = cyc;
        issue(1'b1, 32'h100, 8'd3);
        push_exp(1'b1, 32'h100, 8'd3);
        wait_bursts("t1", 1);
        check_val("t1_arvalid_lat", sar_rise_cyc - n0, 1);
        check_val("t1_ar_hs_lat", ar_hs_cyc - n0, 2);
        check_val("t1_rlast_lat", rlast_cyc - n0, 6);
        check_val("t1_m1_beats", m1_beats, 4);
        check_val("t1_m0_rvalid", m0_rvalid_cnt, 0);
        sample();
        check_val("t1_busy_after", busy, 0);
        check_val("t1_beat_cnt", beat_cnt, 4);
        advance();

        // Simultaneous requests; m0 re-requests once after its first AR
        set_ar_wait(0);
        m0_reissue   = 1;
        m0_next_addr = 32'h240;
        issue(1'b0, 32'h200, 8'd1);
        issue(1'b1, 32'h300, 8'd1);
        push_exp(1'b0, 32'h200, 8'd1);
`ifdef AXI4_RD_ARB_RR_EN
        push_exp(1'b1, 32'h300, 8'd1);
        push_exp(1'b0, 32'h240, 8'd1);
`else
        push_exp(1'b0, 32'h240, 8'd1);
        push_exp(1'b1, 32'h300, 8'd1);
`endif
        wait_bursts("t2", 4);

        // m0 RREADY stall for 3 cycles mid-burst
        base = m0_beats;
        issue(1'b0, 32'h400, 8'd5);
        push_exp(1'b0, 32'h400, 8'd5);
        t = 0;
        while (m0_beats < base + 2 && t < 50) begin
            tick();
            t++;
        end
        check_val("t3_reach_beat2", m0_beats - base, 2);
        m0_r_rdy.RREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            check_val("t3_s_rready_stall", s_r_rdy.RREADY, 0);
            check_val("t3_cnt_hold", beat_cnt, 2);
            advance();
        end
        m0_r_rdy.RREADY = 1'b1;
        wait_bursts("t3", 5);
        sample();
        check_val("t3_beat_cnt", beat_cnt, 6);
        check_val("t3_m0_beats", m0_beats - base, 6);
        advance();

        // Single-beat burst on m1 with m0 pending behind it
        b    = bursts_done;
        base = ar_hs_total;
        issue(1'b1, 32'h500, 8'd0);
        push_exp(1'b1, 32'h500, 8'd0);
        t = 0;
        while (ar_hs_total == base && t < 50) begin
            tick();
            t++;
        end
        issue(1'b0, 32'h600, 8'd1);
        push_exp(1'b0, 32'h600, 8'd1);
        wait_bursts("t4a", b + 1);
        rl = rlast_cyc;
        wait_bursts("t4b", b + 2);
        check_val("t4_idle_gap", busy_rise_cyc - rl, 2);
        check_val("t4_ar_restart", sar_rise_cyc - rl, 2);

        // Reset during DATA at beat 2
        base = m0_beats;
        issue(1'b0, 32'h700, 8'd3);
        push_exp(1'b0, 32'h700, 8'd3);
        t = 0;
        while (m0_beats < base + 2 && t < 50) begin
            tick();
            t++;
        end
        check_val("t5_reach_beat2", m0_beats - base, 2);
        ARESET = 1'b1;
        tick();
        sample();
        check_val("t5_s_arvalid", s_ar.ARVALID, 0);
        check_val("t5_s_rready", s_r_rdy.RREADY, 0);
        check_val("t5_busy", busy, 0);
        check_val("t5_grant", grant, 1);
        check_val("t5_beat_cnt", beat_cnt, 0);
        advance();
        ARESET = 1'b0;

        // Slave stalls ARREADY for 10 ADDR cycles while m1 waits
        b    = bursts_done;
        base = ar_hs_total;
        set_ar_wait(10);
        issue(1'b0, 32'h2C0, 8'd0);
        push_exp(1'b0, 32'h2C0, 8'd0);
        tick();
        issue(1'b1, 32'h3C0, 8'd0);
        push_exp(1'b1, 32'h3C0, 8'd0);
        hold = 0;
        t    = 0;
        do begin
            sample();
            if (s_ar.ARVALID) begin
                hold++;
                check_val("t6_addr_stable", s_ar.ARADDR, 32'h2C0);
                check_val("t6_id_stable", s_ar.ARID, 0);
                check_val("t6_m1_no_arready", m1_ar_rdy.ARREADY, 0);
            end
            advance();
            t++;
        end while (ar_hs_total == base && t < 40);
        check_val("t6_hold_cycles", hold, 11);
        set_ar_wait(0);
        wait_bursts("t6", b + 2);

        tick();
        check_val("exp_ar_left", exp_ar_q.size(), 0);
        check_val("exp_r_left", exp_r_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
